// File: rtl/ram_arbiter_pkg.sv
// ram_arb_pkg: shared state encoding and width helper for the RAM arbiter
package ram_arb_pkg;

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    // Index width that stays legal (at least one bit) even for a single port.
    function automatic int owner_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester bundle plus RAM macro strobes for the arbiter
interface ram_arbiter_if #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);
    import ram_arb_pkg::*;

    localparam int OWNER_W = owner_w(NUM_PORTS);

    logic                        prio_mode_i;
    logic [NUM_PORTS-1:0]        port_en_i;
    logic [NUM_PORTS-1:0]        req_i;
    logic [NUM_PORTS-1:0]        we_i;
    logic [NUM_PORTS*ADDR_W-1:0] addr_i;
    logic [NUM_PORTS*DATA_W-1:0] wdata_i;
    logic [NUM_PORTS-1:0]        gnt_o;
    logic [NUM_PORTS-1:0]        rvalid_o;
    logic [DATA_W-1:0]           rdata_o;
    logic [OWNER_W-1:0]          owner_o;
    logic                        busy_o;
    logic                        ram_en_o;
    logic                        ram_we_o;
    logic [ADDR_W-1:0]           ram_addr_o;
    logic [DATA_W-1:0]           ram_data_o;
    logic [DATA_W-1:0]           ram_data_i;

    modport slave (
        input  prio_mode_i, port_en_i, req_i, we_i, addr_i, wdata_i, ram_data_i,
        output gnt_o, rvalid_o, rdata_o, owner_o, busy_o,
               ram_en_o, ram_we_o, ram_addr_o, ram_data_o
    );

    modport master (
        output prio_mode_i, port_en_i, req_i, we_i, addr_i, wdata_i, ram_data_i,
        input  gnt_o, rvalid_o, rdata_o, owner_o, busy_o,
               ram_en_o, ram_we_o, ram_addr_o, ram_data_o
    );

endinterface

// File: rtl/ram_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first request at or after ptr
module rr_pick #(
    parameter int N = 3,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] hot,
    output logic [W-1:0] idx,
    output logic         valid
);

    // Scan N slots starting at ptr, wrapping, and keep the first hit.
    always_comb begin
        hot   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!valid && req[(int'(ptr) + i) % N]) begin
                valid                     = 1'b1;
                idx                       = W'((int'(ptr) + i) % N);
                hot[(int'(ptr) + i) % N]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: time-shares one single-port RAM among NUM_PORTS requesters
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 8
) (
    input logic          wb_clk_i,
    input logic          wb_rst_i,
    ram_arbiter_if.slave bus
);

    localparam int OW = owner_w(NUM_PORTS);

    state_t               state, state_nxt;
    logic [OW-1:0]        owner, owner_nxt, rr_ptr, rr_ptr_nxt, pick_idx;
    logic [NUM_PORTS-1:0] owner_hot, owner_hot_nxt;
    logic [7:0]           count, count_nxt;
    logic [NUM_PORTS-1:0] elig, gnt, rvalid, pick_req, pick_hot;
    logic                 pick_valid, prio_zero, own_elig, gnt_any, last_beat, preempt;
    logic [ADDR_W-1:0]    own_addr;
    logic [DATA_W-1:0]    own_wdata;

    assign elig      = bus.req_i & bus.port_en_i;
    assign prio_zero = bus.prio_mode_i && elig[0];
    // In priority mode port 0 is handled separately, so the picker only sees the others.
    assign pick_req  = bus.prio_mode_i ? (elig & ~NUM_PORTS'(1)) : elig;

    rr_pick #(.N(NUM_PORTS), .W(OW)) u_pick (
        .req   (pick_req),
        .ptr   (rr_ptr),
        .hot   (pick_hot),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign gnt       = (state == OWN) ? (owner_hot & elig) : '0;
    assign gnt_any   = |gnt;
    assign own_elig  = |(owner_hot & elig);
    assign last_beat = (count == 8'(BURST_MAX - 1));
    assign preempt   = prio_zero && (owner != '0);
    assign own_addr  = bus.addr_i[int'(owner) * ADDR_W +: ADDR_W];
    assign own_wdata = bus.wdata_i[int'(owner) * DATA_W +: DATA_W];

    // Next ownership: pick a winner in IDLE, release after the last beat, loss of eligibility or preemption.
    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        owner_hot_nxt = owner_hot;
        rr_ptr_nxt    = rr_ptr;
        count_nxt     = count;
        if (state == IDLE) begin
            if (prio_zero || pick_valid) begin
                state_nxt     = OWN;
                count_nxt     = '0;
                owner_nxt     = prio_zero ? '0 : pick_idx;
                owner_hot_nxt = prio_zero ? NUM_PORTS'(1) : pick_hot;
            end
        end else begin
            count_nxt = gnt_any ? count + 8'd1 : count;
            if (!own_elig || (gnt_any && last_beat) || preempt) begin
                state_nxt  = IDLE;
                rr_ptr_nxt = OW'((int'(owner) + 1) % NUM_PORTS);
            end
        end
    end

    // Ownership registers plus the read-valid strobe one cycle behind an accepted read.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            owner     <= '0;
            owner_hot <= '0;
            rr_ptr    <= '0;
            count     <= '0;
            rvalid    <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            owner_hot <= owner_hot_nxt;
            rr_ptr    <= rr_ptr_nxt;
            count     <= count_nxt;
            rvalid    <= gnt & ~bus.we_i;
        end
    end

    assign bus.gnt_o      = gnt;
    assign bus.rvalid_o   = rvalid;
    assign bus.rdata_o    = bus.ram_data_i;
    assign bus.owner_o    = owner;
    assign bus.busy_o     = (state == OWN);
    assign bus.ram_en_o   = gnt_any;
    assign bus.ram_we_o   = gnt_any & bus.we_i[owner];
    assign bus.ram_addr_o = gnt_any ? own_addr : '0;
    assign bus.ram_data_o = gnt_any ? own_wdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of ownership, bursts, preemption and read strobes
module tb_ram_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cnt[3];

    logic [2:0] rr_gnt[11]  = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b000, 3'b100, 3'b100, 3'b000, 3'b001};
    logic [2:0] rr_rv[11]   = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b000, 3'b100, 3'b100, 3'b000};
    logic       rr_busy[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] mem[256];

    always #5 clk = ~clk;

    ram_arbiter_if #(.NUM_PORTS(3), .ADDR_W(32), .DATA_W(32)) a ();
    ram_arbiter_if #(.NUM_PORTS(3), .ADDR_W(32), .DATA_W(32)) b ();

    ram_arbiter #(.NUM_PORTS(3), .ADDR_W(32), .DATA_W(32), .BURST_MAX(2)) dut_a (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (a)
    );

    ram_arbiter #(.NUM_PORTS(3), .ADDR_W(32), .DATA_W(32), .BURST_MAX(1)) dut_b (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (b)
    );

    // Single-port RAM model with one cycle read latency behind dut_a.
    always @(posedge clk) begin
        if (a.ram_en_o) begin
            if (a.ram_we_o) mem[a.ram_addr_o[7:0]] <= a.ram_data_o;
            a.ram_data_i <= mem[a.ram_addr_o[7:0]];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a.prio_mode_i = 1'b0; a.port_en_i = 3'b111; a.req_i = '0; a.we_i = '0;
        a.addr_i = '0; a.wdata_i = '0;
        b.prio_mode_i = 1'b0; b.port_en_i = 3'b111; b.req_i = '0; b.we_i = '0;
        b.addr_i = '0; b.wdata_i = '0; b.ram_data_i = '0;
        a.addr_i[32 +: 32]  = 32'h10;
        a.wdata_i[32 +: 32] = 32'hDEADBEEF;

        tick(); #1;
        check("rst_gnt", a.gnt_o, 0);
        check("rst_rvalid", a.rvalid_o, 0);
        check("rst_ram_en", a.ram_en_o, 0);
        check("rst_ram_we", a.ram_we_o, 0);
        check("rst_busy", a.busy_o, 0);
        check("rst_owner", a.owner_o, 0);
        check("rst_addr", a.ram_addr_o, 0);
        check("rst_data", a.ram_data_o, 0);
        check("rst_b_busy", b.busy_o, 0);

        tick(); rst = 1'b0; a.req_i = 3'b010; a.we_i = 3'b010; #1;
        check("sp_idle_gnt", a.gnt_o, 0);
        tick(); #1;
        check("sp_wr_gnt", a.gnt_o, 3'b010);
        check("sp_wr_en", a.ram_en_o, 1);
        check("sp_wr_we", a.ram_we_o, 1);
        check("sp_wr_addr", a.ram_addr_o, 32'h10);
        check("sp_wr_data", a.ram_data_o, 32'hDEADBEEF);
        check("sp_busy", a.busy_o, 1);
        check("sp_owner", a.owner_o, 1);
        tick(); a.we_i = '0; #1;
        check("sp_rd_gnt", a.gnt_o, 3'b010);
        check("sp_rd_we", a.ram_we_o, 0);
        check("sp_wr_no_rvalid", a.rvalid_o, 0);
        tick(); a.req_i = '0; #1;
        check("sp_rvalid", a.rvalid_o, 3'b010);
        check("sp_rdata", a.rdata_o, 32'hDEADBEEF);
        check("sp_done_busy", a.busy_o, 0);
        check("sp_done_gnt", a.gnt_o, 0);

        tick(); rst = 1'b1;
        tick(); rst = 1'b0; a.req_i = 3'b111;
        for (int k = 0; k < 11; k++) begin
            if (k != 0) tick();
            #1;
            check($sformatf("rr_gnt_%0d", k), a.gnt_o, rr_gnt[k]);
            check($sformatf("rr_rvalid_%0d", k), a.rvalid_o, rr_rv[k]);
            check($sformatf("rr_busy_%0d", k), a.busy_o, rr_busy[k]);
        end
        tick(); a.req_i = '0; #1;
        check("rr_release_gnt", a.gnt_o, 0);
        check("rr_release_rvalid", a.rvalid_o, 3'b001);

        tick(); a.prio_mode_i = 1'b1; a.req_i = 3'b100; #1;
        check("pr_idle_gnt", a.gnt_o, 0);
        tick(); a.req_i = 3'b101; #1;
        check("pr_p2_beat", a.gnt_o, 3'b100);
        tick(); #1;
        check("pr_bubble_gnt", a.gnt_o, 0);
        check("pr_bubble_busy", a.busy_o, 0);
        check("pr_p2_rvalid", a.rvalid_o, 3'b100);
        tick(); #1;
        check("pr_p0_gnt", a.gnt_o, 3'b001);
        check("pr_p0_owner", a.owner_o, 0);
        tick(); a.req_i = '0; a.prio_mode_i = 1'b0; #1;
        check("pr_release_gnt", a.gnt_o, 0);
        check("pr_p0_rvalid", a.rvalid_o, 3'b001);

        tick(); a.req_i = 3'b010; #1;
        check("en_idle_gnt", a.gnt_o, 0);
        tick(); #1;
        check("en_rd_gnt", a.gnt_o, 3'b010);
        tick(); a.port_en_i = 3'b101; #1;
        check("en_drop_gnt", a.gnt_o, 0);
        check("en_drop_ram_en", a.ram_en_o, 0);
        check("en_drop_rvalid", a.rvalid_o, 3'b010);
        check("en_drop_rdata", a.rdata_o, 32'hDEADBEEF);
        tick(); #1;
        check("en_idle_busy", a.busy_o, 0);
        check("en_idle_rvalid", a.rvalid_o, 0);

        tick(); a.port_en_i = 3'b111; #1;
        check("rs_idle_gnt", a.gnt_o, 0);
        tick(); #1;
        check("rs_rd_gnt", a.gnt_o, 3'b010);
        tick(); rst = 1'b1; #1;
        check("rs_rvalid", a.rvalid_o, 0);
        check("rs_ram_en", a.ram_en_o, 0);
        check("rs_owner", a.owner_o, 0);
        check("rs_busy", a.busy_o, 0);
        check("rs_gnt", a.gnt_o, 0);
        tick(); rst = 1'b0; a.req_i = '0;

        tick(); b.req_i = 3'b111;
        for (int k = 0; k < 30; k++) begin
            logic [2:0] e;
            if (k != 0) tick();
            #1;
            e = (k % 2 == 1) ? 3'(1 << (((k - 1) / 2) % 3)) : 3'b000;
            check($sformatf("b1_gnt_%0d", k), b.gnt_o, e);
            for (int p = 0; p < 3; p++) cnt[p] += int'(b.gnt_o[p]);
        end
        for (int p = 0; p < 3; p++) check($sformatf("b1_count_p%0d", p), cnt[p], 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Parametrised multi-port arbiter that gives NUM_PORTS requesters (Baby core, SPI loader, Wishbone config, future masters) time-shared access to one single-port RAM. It replaces static halt/chip-select routing with a registered ownership state machine, per-port enables, fixed-priority or round-robin selection, bounded bursts and per-port read-data-valid strobes. It sits between the requesters and the RAM macro in the user project wrapper.

## Interface
Parameters:
- NUM_PORTS, 3: number of requesters; port 0 is the Baby core.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- BURST_MAX, 8: maximum accesses per ownership before re-arbitration; 1..255.

Ports:
- wb_clk_i  in  1  single clock for arbiter, requesters and RAM.
- wb_rst_i  in  1  asynchronous, active-high reset.
- prio_mode_i  in  1  1 = port 0 fixed highest priority; 0 = round-robin.
- port_en_i  in  NUM_PORTS  per-port eligibility; replaces halt/cs/config_en gating.
- req_i  in  NUM_PORTS  per-port access request, level.
- we_i  in  NUM_PORTS  per-port write enable.
- addr_i  in  NUM_PORTS*ADDR_W  packed addresses, port p at [p*ADDR_W +: ADDR_W].
- wdata_i  in  NUM_PORTS*DATA_W  packed write data.
- gnt_o  out  NUM_PORTS  access accepted this cycle (one-hot or zero).
- rvalid_o  out  NUM_PORTS  read data valid for port, one-hot or zero.
- rdata_o  out  DATA_W  read data, broadcast to all ports.
- owner_o  out  clog2(NUM_PORTS)  current owner index.
- busy_o  out  1  high in OWN.
- ram_en_o, ram_we_o  out  1  RAM strobe and write enable.
- ram_addr_o  out  ADDR_W; ram_data_o  out  DATA_W; ram_data_i  in  DATA_W (read latency 1).

## Operation
- Eligible port: req_i[p] & port_en_i[p].
- States: IDLE, OWN.
- IDLE: no access. If any eligible port, pick winner, register owner, clear beat count, go OWN. prio_mode_i=1: port 0 if eligible, else round-robin among others; prio_mode_i=0: round-robin starting at rr_ptr.
- OWN: gnt_o[owner] = req_i[owner] & port_en_i[owner], combinational. On gnt: ram_en_o=1, ram_we_o/addr/data = owner's we/addr/wdata; beat count increments.
- Leave OWN to IDLE when: owner not eligible this cycle; or granted beat is beat BURST_MAX; or prio_mode_i=1, owner≠0 and port 0 eligible (preempt after current beat). On leaving, rr_ptr = owner+1 mod NUM_PORTS.
- Read: accepted read (gnt & !we) → rvalid_o[owner] pulses next cycle with rdata_o = ram_data_i. Writes produce no rvalid.
- rdata_o = ram_data_i unconditionally; consumers qualify with rvalid_o.
- Only one port ever granted; non-owners see gnt_o=0 and must hold req.

## Timing
- Reset values: state IDLE, owner 0, rr_ptr 0, count 0, gnt_o 0, rvalid_o 0, ram_en_o 0, ram_we_o 0, busy_o 0; ram_addr_o/ram_data_o 0.
- Arbitration latency: 1 cycle (req at cycle n in IDLE → first gnt at n+1).
- Burst throughput: 1 access/cycle while owner holds req; one IDLE bubble between ownerships.
- Read latency: rvalid at gnt+1.
- port_en_i drop mid-burst: gnt falls same cycle; pending rvalid from previous beat still delivered.
- Reset mid-burst: outputs to reset values immediately; pending rvalid discarded.
- Simultaneous requests in IDLE: resolved per mode; NUM_PORTS=1 degenerates to always-owner 0.

## Structure
- Package ram_arb_pkg: state enum (IDLE, OWN), OWNER_W = clog2 helper.
- Sub-module rr_pick: combinational round-robin picker (req vector, start pointer → one-hot + index, valid).

## Test plan
- Single port: port 1 req, addr 0x10, write 0xDEADBEEF, then read → gnt one cycle after req, rvalid_o=3'b010 with rdata 0xDEADBEEF one cycle after read gnt.
- Round-robin: prio_mode=0, ports 0,1,2 req continuously, BURST_MAX=2 → grant order 0,0,1,1,2,2,0 with one bubble per switch.
- Priority preempt: prio_mode=1, port 2 bursting, port 0 requests → port 2 finishes current beat, port 0 granted after one IDLE cycle.
- Enable drop: port 1 reading burst, port_en_i[1] falls → gnt_o[1]=0 same cycle, rvalid for last accepted beat still issued, IDLE next cycle.
- Reset mid-read: assert wb_rst_i the cycle after a read gnt → rvalid_o stays 0, ram_en_o 0, owner_o 0.
- BURST_MAX=1 all-eligible: grants strictly alternate with one bubble; no port starved over 30 cycles.
